// File: rtl/if_id_skid.sv
// ---------------------------------------------------------------------------
// if_id_skid
//   Fetch-to-decode pipeline register with a two-entry skid buffer. Beats
//   from the fetch unit are presented to decode in the order they arrive.
//   ready_o depends only on internal state, so there is no combinational
//   path from decode's ready back to fetch.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   valid_i      fetch presents a beat
//   inst_i       fetched instruction
//   inst_addr_i  fetched instruction address
//   ready_o      buffer can accept a beat this cycle
//   valid_o      beat available to decode
//   inst_o       instruction to decode (NOP_INST when empty)
//   inst_addr_o  instruction address to decode (0 when empty)
//   ready_i      decode / ID-EX can accept
//   hold_flag_i  pipeline control; only PIPE_CLEAR is acted on
//   count_o      occupancy 0..2
// ---------------------------------------------------------------------------
module if_id_skid #(
    parameter int                DW         = 32,
    parameter int                AW         = 32,
    parameter logic [DW-1:0]     NOP_INST   = 32'h00000013,
    parameter int                HOLD_W     = 3,
    parameter logic [HOLD_W-1:0] PIPE_CLEAR = 3'd1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic [DW-1:0]     inst_i,
    input  logic [AW-1:0]     inst_addr_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DW-1:0]     inst_o,
    output logic [AW-1:0]     inst_addr_o,
    input  logic              ready_i,
    input  logic [HOLD_W-1:0] hold_flag_i,
    output logic [1:0]        count_o
);

    // The state encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state;
    logic          main_valid;
    logic          skid_valid;
    logic [DW-1:0] main_inst;
    logic [AW-1:0] main_addr;
    logic [DW-1:0] skid_inst;
    logic [AW-1:0] skid_addr;

    logic accept;
    logic take;
    logic flush;

    // Valid bits are decoded from the state, which guarantees that the skid
    // entry is never valid without the main entry.
    assign main_valid = (state != EMPTY);
    assign skid_valid = (state == FULL);

    assign ready_o     = ~skid_valid;
    assign valid_o     = main_valid;
    assign inst_o      = main_valid ? main_inst : NOP_INST;
    assign inst_addr_o = main_valid ? main_addr : '0;
    assign count_o     = {1'b0, main_valid} + {1'b0, skid_valid};

    assign accept = valid_i & ready_o;
    assign take   = valid_o & ready_i;
    assign flush  = (hold_flag_i == PIPE_CLEAR);

    // Occupancy state machine plus payload registers. Payloads only load when
    // a beat lands in them; otherwise they hold. A flush empties the buffer
    // and discards any beat accepted in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= EMPTY;
            main_inst <= '0;
            main_addr <= '0;
            skid_inst <= '0;
            skid_addr <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_inst <= inst_i;
                        main_addr <= inst_addr_i;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        main_inst <= inst_i;
                        main_addr <= inst_addr_i;
                    end else if (accept) begin
                        // Decode stalled: park the new beat behind main.
                        skid_inst <= inst_i;
                        skid_addr <= inst_addr_i;
                        state     <= FULL;
                    end else if (take) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // ready_o is low here, so only a take can move things.
                    if (take) begin
                        main_inst <= skid_inst;
                        main_addr <= skid_addr;
                        state     <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule
